c_fetch_align: RTL and testbench
================================

Name: c_fetch_align

Overview:
- Fetch-side realignment controller that sits between the word-aligned instruction memory port and the compressed-instruction decoder.
- Holds a 3-halfword queue and issues word fetches, one outstanding at a time.
- Presents one aligned instruction per handshake, either a 16-bit compressed instruction or a 32-bit one. The 32-bit case includes instructions that straddle a word boundary.
- Sequences the PC by +2 or +4 and handles redirects (branch/jump/trap) by flushing the queue and discarding in-flight data.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bit 0 must be 0.
ADDR_W, 32, width of PC and memory address.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
redirect_i  input  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  input  ADDR_W  new PC, halfword aligned; bit 0 ignored
imem_req_o  output  1  word fetch request
imem_addr_o  output  ADDR_W  fetch address, bits [1:0] always 0
imem_gnt_i  input  1  request accepted this cycle
imem_rsp_valid_i  input  1  read data valid, one cycle per granted request
imem_rdata_i  input  32  fetched word; [15:0] is the lower-address halfword
instr_valid_o  output  1  instr_o/instr_pc_o/instr_comp_o valid
instr_ready_i  input  1  consumer accepts instruction
instr_o  output  32  {hw1,hw0} if full; {16'h0,hw0} if compressed
instr_pc_o  output  ADDR_W  PC of instr_o
instr_comp_o  output  1  1 when hw0[1:0] != 2'b11

Behaviour:
- Reset (rst=1 at posedge):
  - queue count=0, drop=0, fetch FSM=F_IDLE.
  - out_pc=RESET_PC, fetch_addr={RESET_PC[ADDR_W-1:2],2'b00}, skip_lo=RESET_PC[1].
  - imem_req_o=0, instr_valid_o=0, all other outputs 0.
  - Reset overrides redirect and all handshakes in the same cycle.
- Queue:
  - hw0..hw2, count 0..3; hw0 is at out_pc.
  - instr_comp_o = (hw0[1:0] != 2'b11).
  - instr_valid_o = (count>=1 && comp) || (count>=2 && !comp). This is combinational from registered state; there is no ready-to-valid path.
  - On instr_valid_o && instr_ready_i: pop 1 halfword (comp) or 2 (full), out_pc += 2 or 4.
  - hw 16'h0000 is treated as compressed; it is passed through, and illegal detection is downstream.
- Fetch FSM:
  - F_IDLE: enter F_REQ when count<=1 (after this cycle's pop) and no response is outstanding.
  - F_REQ: imem_req_o=1, imem_addr_o=fetch_addr held stable until imem_gnt_i. On gnt, go to F_WAIT and fetch_addr += 4.
  - F_WAIT: on imem_rsp_valid_i, go to F_IDLE.
    - If drop=1: discard the data and clear drop.
    - Else if skip_lo=1: push rdata[31:16] only, then clear skip_lo.
    - Else push rdata[15:0] then rdata[31:16].
  - Push and pop in the same cycle: count_next = count - pop + push. This never exceeds 3 because the fetch gate is count<=1.
- Redirect (redirect_i=1, has priority over handshake effects):
  - Next cycle: count=0, out_pc={redirect_pc_i[ADDR_W-1:1],1'b0}, fetch_addr=word of redirect_pc_i, skip_lo=redirect_pc_i[1].
  - A pop in the same cycle is still a legal consumer handshake, but the queue/PC update is overridden.
  - In F_REQ: the request to the old address is kept until gnt; drop=1 is set and the FSM moves to F_WAIT on gnt.
  - In F_WAIT: set drop=1. If imem_rsp_valid_i is in the same cycle, that response is discarded and drop stays 0.
  - In F_IDLE: no drop; the next request uses the new fetch_addr.
  - Back-to-back redirects: the last one wins; drop remains a single bit because at most one response is outstanding.
- Address arithmetic wraps modulo 2^ADDR_W.
- Minimum latency: redirect -> instr_valid_o is 3 cycles with gnt in the request cycle and rsp one cycle later.

Decomposition:
- Shared package (pcore_interface_defs) adds:
  - C_OPC_FULL = 2'b11.
  - typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} type_fetch_align_state_e.
  - type_fetch_align_if struct bundling instr/pc/comp/valid for the decoder interface.
- One natural sub-module: c_hw_queue, a 3-entry halfword shift queue with push-1/push-2 and pop-1/pop-2, count output, and flush.

Test Plan:
- Reset RESET_PC=0; words @0=32'h4501_0001, @4=32'h0000_0513:
  - imem_addr_o=0 first.
  - Outputs: pc0 comp instr 16'h0001, pc2 comp 16'h4501, pc4 full 32'h0000_0513.
- Straddle: @0=32'h0513_0001, @4=32'h0001_0000. Expect pc0 comp 16'h0001, then pc2 full instr_o=32'h0000_0513, assembled across the word boundary.
- Redirect to 32'h0000_0102 while in F_WAIT:
  - Pending response discarded.
  - Next fetch addr 32'h0000_0100.
  - Only rdata[31:16] queued; first output pc=32'h102.
- instr_ready_i=0 for 10 cycles with the queue full: count stays 3, imem_req_o=0, instr_valid_o and instr_o held stable.
- Redirect, rsp_valid and handshake in the same cycle: the response is not queued, count=0 next cycle, and out_pc equals the redirect target.
- Assert rst mid-F_REQ: next cycle imem_req_o=0, instr_valid_o=0, out_pc=RESET_PC; a later stray rsp_valid is ignored.

Source files
------------

// File: rtl/pcore_interface_defs.sv
// Shared definitions for the fetch/decode boundary of the core.
// Holds the fetch-align FSM states and the decoder-facing bundle.
package pcore_interface_defs;

    localparam logic [1:0] C_OPC_FULL = 2'b11;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT
    } type_fetch_align_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
        logic        valid;
    } type_fetch_align_if;

endpackage

// File: rtl/c_hw_queue.sv
// Three-entry halfword shift queue; entry 0 is the oldest halfword.
// Supports pop of 0-2 and push of 0-2 halfwords in the same cycle.
module c_hw_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  pop_n,
    input  logic [1:0]  push_n,
    input  logic [15:0] push_d0,
    input  logic [15:0] push_d1,
    output logic [15:0] hw0,
    output logic [15:0] hw1,
    output logic [1:0]  count
);

    logic [2:0][15:0] q;
    logic [2:0][15:0] q_n;
    logic [2:0][15:0] shifted;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_n;
    logic [1:0]       base;

    always_comb begin
        shifted = q;
        unique case (pop_n)
            2'd1:    shifted = {16'h0, q[2], q[1]};
            2'd2:    shifted = {16'h0, 16'h0, q[2]};
            default: shifted = q;
        endcase
    end

    // New halfwords land directly behind whatever survives the pop.
    always_comb begin
        base  = cnt_q - pop_n;
        cnt_n = base + push_n;
        q_n   = shifted;
        for (int i = 0; i < 3; i++) begin
            if (push_n != 2'd0 && 2'(i) == base)
                q_n[i] = push_d0;
            else if (push_n == 2'd2 && 2'(i) == base + 2'd1)
                q_n[i] = push_d1;
        end
        if (flush) begin
            cnt_n = 2'd0;
            q_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            cnt_q <= 2'd0;
        end else begin
            q     <= q_n;
            cnt_q <= cnt_n;
        end
    end

    assign hw0   = q[0];
    assign hw1   = q[1];
    assign count = cnt_q;

endmodule

// File: rtl/c_fetch_align.sv
// Fetch realignment: word fetches in, aligned 16/32-bit instructions out.
// One outstanding fetch; redirects flush the queue and drop in-flight data.
module c_fetch_align
    import pcore_interface_defs::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rsp_valid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_comp_o
);

    type_fetch_align_state_e state;
    type_fetch_align_state_e state_n;

    logic [15:0]       hw0;
    logic [15:0]       hw1;
    logic [1:0]        count;
    logic [1:0]        cnt_after_pop;
    logic [1:0]        pop_n;
    logic [1:0]        push_n;
    logic [15:0]       push_d0;
    logic              comp;
    logic              valid;
    logic              fire;
    logic              rsp_take;
    logic              push_ok;
    logic              drop;
    logic              skip_lo;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] redir_hw;
    logic [ADDR_W-1:0] redir_word;

    assign redir_hw   = redirect_pc_i & ~ADDR_W'(1);
    assign redir_word = redirect_pc_i & ~ADDR_W'(3);

    assign comp  = (hw0[1:0] != C_OPC_FULL);
    assign valid = (count != 2'd0 && comp) || (count >= 2'd2 && !comp);
    assign fire  = valid && instr_ready_i;
    assign pop_n = !fire ? 2'd0 : (comp ? 2'd1 : 2'd2);

    assign rsp_take = (state == F_WAIT) && imem_rsp_valid_i;
    assign push_ok  = rsp_take && !drop && !redirect_i;
    assign push_n   = !push_ok ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
    assign push_d0  = skip_lo ? imem_rdata_i[31:16] : imem_rdata_i[15:0];

    assign cnt_after_pop = redirect_i ? 2'd0 : count - pop_n;

    c_hw_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_i),
        .pop_n   (pop_n),
        .push_n  (push_n),
        .push_d0 (push_d0),
        .push_d1 (imem_rdata_i[31:16]),
        .hw0     (hw0),
        .hw1     (hw1),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= F_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            F_IDLE: if (cnt_after_pop <= 2'd1) state_n = F_REQ;
            F_REQ:  if (imem_gnt_i) state_n = F_WAIT;
            F_WAIT: if (imem_rsp_valid_i) state_n = F_IDLE;
            default: state_n = F_IDLE;
        endcase
    end

    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = '0;
        if (state == F_REQ) begin
            imem_req_o  = 1'b1;
            imem_addr_o = req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc     <= RESET_PC;
            fetch_addr <= RESET_PC & ~ADDR_W'(3);
            req_addr   <= '0;
            skip_lo    <= RESET_PC[1];
            drop       <= 1'b0;
        end else begin
            if (redirect_i)
                out_pc <= redir_hw;
            else if (fire)
                out_pc <= out_pc + ADDR_W'(comp ? 2 : 4);

            // A redirect taken while in F_REQ already moved fetch_addr.
            if (redirect_i)
                fetch_addr <= redir_word;
            else if (state == F_REQ && imem_gnt_i && !drop)
                fetch_addr <= fetch_addr + ADDR_W'(4);

            if (state == F_IDLE && state_n == F_REQ)
                req_addr <= redirect_i ? redir_word : fetch_addr;

            if (redirect_i)
                skip_lo <= redirect_pc_i[1];
            else if (push_ok)
                skip_lo <= 1'b0;

            if (rsp_take)
                drop <= 1'b0;
            else if (redirect_i && state != F_IDLE)
                drop <= 1'b1;
        end
    end

    assign instr_valid_o = valid;
    assign instr_comp_o  = valid && comp;
    assign instr_pc_o    = valid ? out_pc : '0;
    assign instr_o       = !valid ? 32'h0 :
                           comp   ? {16'h0, hw0} : {hw1, hw0};

endmodule

// File: tb/tb_c_fetch_align.sv
// Randomized scoreboard bench for c_fetch_align against a PC-walk model.
module tb_c_fetch_align;
    import pcore_interface_defs::*;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_comp_o;

    always #5 clk = ~clk;

    c_fetch_align #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rdata_i     (imem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_comp_o     (instr_comp_o)
    );

    logic [31:0] mem [256];
    type_fetch_align_if sb[$];
    int checks = 0;
    int passed = 0;

    bit gnt_en  = 1'b1;
    int gnt_pct = 100;
    int lat_lo  = 0;
    int lat_hi  = 0;
    bit stray   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, act, exp, $time);
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Expected stream: walk memory from the start PC by instruction length.
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] pc;
        logic [15:0] h;
        type_fetch_align_if e;
        sb.delete();
        pc = start & ~32'h1;
        for (int i = 0; i < 1000; i++) begin
            h       = hw_at(pc);
            e.valid = 1'b1;
            e.pc    = pc;
            if (h[1:0] == 2'b11) begin
                e.comp  = 1'b0;
                e.instr = {hw_at(pc + 32'd2), h};
                pc      = pc + 32'd4;
            end else begin
                e.comp  = 1'b1;
                e.instr = {16'h0, h};
                pc      = pc + 32'd2;
            end
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        type_fetch_align_if e;
        if (!rst && instr_valid_o && instr_ready_i) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("instr", instr_o, e.instr);
                check("pc", instr_pc_o, e.pc);
                check("comp", {31'b0, instr_comp_o}, {31'b0, e.comp});
            end
        end
    end

    // Memory port: random grant, one response after a random delay.
    initial begin
        bit          outst;
        int          dly;
        logic [31:0] raddr;
        outst = 1'b0;
        dly = 0;
        raddr = '0;
        imem_gnt_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid_i = 1'b0;
            imem_rdata_i = $urandom;
            if (stray) begin
                imem_rsp_valid_i = 1'b1;
                stray = 1'b0;
            end else if (outst) begin
                if (dly == 0) begin
                    imem_rsp_valid_i = 1'b1;
                    imem_rdata_i = mem[raddr[9:2]];
                    outst = 1'b0;
                end else begin
                    dly--;
                end
            end
            imem_gnt_i = 1'b0;
            if (imem_req_o && !outst && gnt_en &&
                int'($urandom_range(99)) < gnt_pct) begin
                imem_gnt_i = 1'b1;
                raddr = imem_addr_o;
                outst = 1'b1;
                dly = int'($urandom_range(lat_hi, lat_lo));
                check("addr_align", {30'b0, imem_addr_o[1:0]}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(3) == 0)
            return 32'hFFFF_FFF0 | (t & 32'hF);
        return t & 32'h3FF;
    endfunction

    task automatic begin_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        redirect_i = 1'b0;
        instr_ready_i = 1'b0;
    endtask

    task automatic end_reset();
        load_stream(RESET_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'd0);
        check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
    endtask

    task automatic step(input int rdy_pct, input int redir_pct);
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        instr_ready_i = int'($urandom_range(99)) < rdy_pct;
        redirect_i = 1'b0;
        if (int'($urandom_range(99)) < redir_pct) begin
            tgt = rand_target() | {31'b0, 1'($urandom)};
            redirect_i = 1'b1;
            redirect_pc_i = tgt;
            @(negedge clk);
            #1;
            load_stream(tgt);
        end
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        @(posedge clk);
        #1;
        redirect_i = 1'b1;
        redirect_pc_i = tgt;
        @(negedge clk);
        #1;
        load_stream(tgt);
        @(posedge clk);
        #1;
        redirect_i = 1'b0;
    endtask

    task automatic wait_req(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #2;
            if (imem_req_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check("timeout_req", 32'd0, 32'd1);
    endtask

    initial begin
        bit          ok;
        logic [31:0] held;
        rst = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 256; i++)
            mem[i] = $urandom;

        // Basic sequence from reset: two compressed then one full.
        mem[0] = 32'h4501_0001;
        mem[1] = 32'h0000_0513;
        begin_reset();
        end_reset();
        wait_req(20, ok);
        if (ok)
            check("first_addr", imem_addr_o, 32'h0);
        repeat (12) step(100, 0);

        lat_hi = 2;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0)
                gnt_pct = 30 + int'($urandom_range(70));
            step(70, 4);
        end

        // Full instruction straddling the word boundary.
        begin_reset();
        mem[0] = 32'h0513_0001;
        mem[1] = 32'h0001_0000;
        gnt_pct = 100;
        lat_hi = 0;
        end_reset();
        repeat (12) step(100, 0);

        // Redirect while a response is pending.
        lat_lo = 2;
        lat_hi = 2;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = imem_gnt_i;
        end
        if (!ok)
            check("timeout_gnt", 32'd0, 32'd1);
        do_redirect(32'h0000_0102);
        wait_req(20, ok);
        if (ok)
            check("redir_addr", imem_addr_o, 32'h0000_0100);
        lat_lo = 0;
        lat_hi = 1;
        repeat (15) step(100, 0);

        // Consumer stall with three halfwords queued.
        @(posedge clk);
        #1;
        instr_ready_i = 1'b0;
        do_redirect(32'h0000_0202);
        repeat (20) @(posedge clk);
        #1;
        held = instr_o;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_req", {31'b0, imem_req_o}, 32'd0);
            check("stall_valid", {31'b0, instr_valid_o}, 32'd1);
            check("stall_instr", instr_o, held);
        end
        repeat (10) step(100, 0);

        // Redirect, response and handshake all in one cycle.
        begin_reset();
        for (int i = 0; i < 256; i++)
            mem[i] = $urandom & 32'hFFFC_FFFC;
        end_reset();
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #1;
            instr_ready_i = 1'($urandom);
            #1;
            if (imem_rsp_valid_i && instr_valid_o) begin
                ok = 1'b1;
                instr_ready_i = 1'b1;
                redirect_i = 1'b1;
                redirect_pc_i = 32'h0000_01A6;
                @(negedge clk);
                #1;
                load_stream(32'h0000_01A6);
                @(posedge clk);
                #1;
                redirect_i = 1'b0;
                check("flush_valid", {31'b0, instr_valid_o}, 32'd0);
            end
        end
        if (!ok)
            check("timeout_coincide", 32'd0, 32'd1);
        repeat (15) step(100, 0);

        // Reset while a request waits for grant, then a stray response.
        for (int i = 0; i < 256; i++)
            mem[i] = $urandom;
        gnt_en = 1'b0;
        wait_req(40, ok);
        begin_reset();
        end_reset();
        stray = 1'b1;
        repeat (4) step(60, 0);
        gnt_en = 1'b1;
        repeat (20) step(100, 0);

        lat_hi = 2;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0)
                gnt_pct = 20 + int'($urandom_range(80));
            if ($urandom_range(199) == 0) begin
                begin_reset();
                end_reset();
            end else begin
                step(60, 5);
            end
        end
        repeat (30) step(100, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
